// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped countdown timer:
// register offsets, CTRL bit layout, mode codes and FSM encoding.
package timer_dev_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer on the device side of the MEM stage.
// CTRL/PRESET/COUNT word registers, 4-state FSM, level irq to CP0.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    logic [3:0]        r_ctrl;
    logic [DATA_W-1:0] r_preset;
    logic [DATA_W-1:0] r_count;
    logic              r_irq_flag;
    state_t            r_state;

    state_t            w_state_nxt;
    logic              w_load;
    logic              w_dec;
    logic              w_set_flag;
    logic              w_clr_fsm;
    logic              w_en_clr;

    logic [31:0]       w_off;
    logic [1:0]        w_reg;
    logic              w_wr_ctrl;
    logic              w_wr_preset;
    logic              w_en;
    logic              w_periodic;
    logic              w_unused;

    // BASE_ADDR is 16-byte aligned, so only the word index matters.
    assign w_off       = addr - BASE_ADDR;
    assign w_reg       = w_off[3:2];
    assign w_unused    = &{1'b0, w_off[31:4], w_off[1:0]};

    assign w_wr_ctrl   = sel & we & (w_reg == OFF_CTRL);
    assign w_wr_preset = sel & we & (w_reg == OFF_PRESET);
    assign w_en        = r_ctrl[CTRL_EN];
    assign w_periodic  = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO]
                          == MODE_PERIODIC);

    assign irq = r_irq_flag & r_ctrl[CTRL_IM];

    // Zero-latency read mux over the register file.
    always_comb begin
        rdata = '0;
        case (w_reg)
            OFF_CTRL:   rdata = {{(DATA_W-4){1'b0}}, r_ctrl};
            OFF_PRESET: rdata = r_preset;
            OFF_COUNT:  rdata = r_count;
            default:    rdata = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state and datapath strobes; modes 2/3 act as one-shot.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_set_flag  = 1'b0;
        w_clr_fsm   = 1'b0;
        w_en_clr    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_en) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!w_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count != '0) begin
                    w_dec = 1'b1;
                end else begin
                    w_set_flag  = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                if (w_periodic) begin
                    w_clr_fsm   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_en_clr    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // CTRL: a CPU write takes priority over the one-shot EN clear.
    always_ff @(posedge clk) begin
        if (reset)          r_ctrl <= '0;
        else if (w_wr_ctrl) r_ctrl <= wdata[3:0];
        else if (w_en_clr)  r_ctrl[CTRL_EN] <= 1'b0;
    end

    // PRESET: only sampled by LOAD, so mid-count writes wait a period.
    always_ff @(posedge clk) begin
        if (reset)            r_preset <= '0;
        else if (w_wr_preset) r_preset <= wdata;
    end

    // COUNT: reload or decrement; never wraps since dec needs COUNT!=0.
    always_ff @(posedge clk) begin
        if (reset)       r_count <= '0;
        else if (w_load) r_count <= r_preset;
        else if (w_dec)  r_count <= r_count - DATA_W'(1);
    end

    // irq_flag: FSM set beats any clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset)
            r_irq_flag <= 1'b0;
        else if (w_set_flag)
            r_irq_flag <= 1'b1;
        else if (w_wr_ctrl | w_wr_preset | w_clr_fsm)
            r_irq_flag <= 1'b0;
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: stimulus pushes expected rdata/irq
// into a scoreboard; a monitor pops and compares on each sample strobe.
module tb_timer_dev;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSV    = 32'h0000_7F0C;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    event sample_ev;

    always #10 clk = ~clk;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    // Monitor: pops one expectation per sample strobe.
    always @(sample_ev) begin
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow");
        end else begin
            mon_e = sb.pop_front();
            if (rdata !== mon_e.rd) begin
                failures++;
                $display("FAIL %s rdata got=%h exp=%h",
                         mon_e.name, rdata, mon_e.rd);
            end
            checks++;
            if (irq !== mon_e.irq) begin
                failures++;
                $display("FAIL %s irq got=%b exp=%b",
                         mon_e.name, irq, mon_e.irq);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick(1);
        sel   = 1'b0;
        we    = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] rd, input logic ir);
        exp_t e;
        e.name = nm;
        e.rd   = rd;
        e.irq  = ir;
        addr   = a;
        sb.push_back(e);
        #1;
        ->sample_ev;
        #1;
    endtask

    function automatic logic [31:0] per_count(input int p);
        // Period-5 COUNT trace for PRESET=2, phase 0 = just loaded.
        if (p == 0)      return 32'd2;
        else if (p == 1) return 32'd1;
        else             return 32'd0;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        tick(2);
        reset = 1'b0;

        // Reset state.
        chk("rst_ctrl",   A_CTRL,   32'd0, 1'b0);
        chk("rst_preset", A_PRESET, 32'd0, 1'b0);
        chk("rst_count",  A_COUNT,  32'd0, 1'b0);
        chk("rst_rsv",    A_RSV,    32'd0, 1'b0);

        // One-shot, PRESET=3, IM on. CTRL write is edge t.
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'h9);
        tick(1);
        for (int j = 0; j < 4; j++) begin
            tick(1);
            chk("os_count", A_COUNT, 32'(3 - j), 1'b0);
        end
        tick(1);
        chk("os_irq_set", A_COUNT, 32'd0, 1'b1);
        tick(1);
        chk("os_en_clr", A_CTRL, 32'h8, 1'b1);
        tick(3);
        chk("os_irq_held", A_COUNT, 32'd0, 1'b1);
        wr(A_PRESET, 32'd7);
        chk("os_irq_drop", A_PRESET, 32'd7, 1'b0);

        // Periodic, PRESET=2, IM on: pulse every 5 cycles.
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'hB);
        tick(1);
        for (int k = 2; k <= 17; k++) begin
            tick(1);
            chk("per_im1", A_COUNT, per_count((k - 2) % 5),
                ((k - 2) % 5) == 3);
        end
        wr(A_CTRL, 32'h0);
        tick(3);

        // Same periodic run with IM off: irq stays low.
        wr(A_CTRL, 32'h3);
        tick(1);
        for (int k = 2; k <= 17; k++) begin
            tick(1);
            chk("per_im0", A_COUNT, per_count((k - 2) % 5), 1'b0);
        end
        wr(A_CTRL, 32'h0);
        tick(3);

        // Halt mid-count: EN cleared on the edge that makes COUNT 6.
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h9);
        tick(5);
        chk("halt_pre", A_COUNT, 32'd7, 1'b0);
        wr(A_CTRL, 32'h8);
        chk("halt_edge", A_COUNT, 32'd6, 1'b0);
        tick(3);
        chk("halt_frozen", A_COUNT, 32'd6, 1'b0);
        chk("halt_ctrl", A_CTRL, 32'h8, 1'b0);
        wr(A_CTRL, 32'h9);
        tick(2);
        chk("halt_reload", A_COUNT, 32'd10, 1'b0);
        wr(A_CTRL, 32'h0);
        tick(3);

        // PRESET change mid-period in periodic mode.
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'hB);
        tick(2);
        chk("pw_c3", A_COUNT, 32'd3, 1'b0);
        tick(1);
        chk("pw_c2", A_COUNT, 32'd2, 1'b0);
        wr(A_PRESET, 32'd5);
        chk("pw_c1", A_COUNT, 32'd1, 1'b0);
        tick(1);
        chk("pw_c0", A_COUNT, 32'd0, 1'b0);
        tick(1);
        chk("pw_irq1", A_COUNT, 32'd0, 1'b1);
        tick(1);
        chk("pw_load", A_COUNT, 32'd0, 1'b0);
        tick(1);
        chk("pw_new5", A_COUNT, 32'd5, 1'b0);
        tick(4);
        chk("pw_c1b", A_COUNT, 32'd1, 1'b0);
        tick(1);
        chk("pw_c0b", A_COUNT, 32'd0, 1'b0);
        tick(1);
        chk("pw_irq2", A_COUNT, 32'd0, 1'b1);
        wr(A_CTRL, 32'h2);
        tick(2);
        chk("pw_stop", A_COUNT, 32'd5, 1'b0);
        tick(2);
        chk("pw_frozen", A_COUNT, 32'd5, 1'b0);

        // Writes to COUNT and reserved offsets are ignored.
        wr(A_COUNT, 32'h0000_1234);
        wr(A_RSV, 32'hFFFF_FFFF);
        chk("ro_ctrl",   A_CTRL,   32'h2, 1'b0);
        chk("ro_preset", A_PRESET, 32'd5, 1'b0);
        chk("ro_count",  A_COUNT,  32'd5, 1'b0);
        chk("ro_rsv",    A_RSV,    32'd0, 1'b0);

        // Reset mid-count while a CTRL write is presented.
        wr(A_PRESET, 32'd6);
        wr(A_CTRL, 32'h1);
        tick(4);
        chk("mr_pre", A_COUNT, 32'd4, 1'b0);
        reset = 1'b1;
        sel   = 1'b1;
        we    = 1'b1;
        addr  = A_CTRL;
        wdata = 32'hF;
        tick(1);
        reset = 1'b0;
        sel   = 1'b0;
        we    = 1'b0;
        chk("mr_ctrl",   A_CTRL,   32'd0, 1'b0);
        chk("mr_preset", A_PRESET, 32'd0, 1'b0);
        chk("mr_count",  A_COUNT,  32'd0, 1'b0);
        tick(4);
        chk("mr_idle", A_COUNT, 32'd0, 1'b0);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0",
                     sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
